// File: rtl/piano_pkg.sv
// Shared constants and types for the piano key front end.
// Used by the key encoder and the downstream note-select decoders.
package piano_pkg;

  localparam int N_KEYS = 8;
  localparam int CODE_W = $clog2(N_KEYS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  typedef logic [CODE_W-1:0] note_code_t;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic more_than_one(input logic [N_KEYS-1:0] v);
    return (v & (v - N_KEYS'(1))) != {N_KEYS{1'b0}};
  endfunction

endpackage

// File: rtl/prio_encoder.sv
// Lowest-index-first priority encoder: key line 0 wins over all others.
// Purely combinational; cand_code is 0 when no line is set.
module prio_encoder
  import piano_pkg::*;
(
  input  logic [N_KEYS-1:0] key_q,
  output logic [CODE_W-1:0] cand_code,
  output logic              cand_any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    cand_code = {CODE_W{1'b0}};
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      cand_code = key_q[i] ? CODE_W'(i) : cand_code;
    end
  end

  assign cand_any = |key_q;

endmodule

// File: rtl/key_encoder.sv
// Piano key encoder: gated key lines -> debounced binary note code with
// note_on/note_off event pulses and a registered multi-key flag.
module key_encoder
  import piano_pkg::*;
#(
  parameter int DEB_CYCLES = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys,
  input  logic              enable,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              note_on,
  output logic              note_off,
  output logic              multi
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_KEYS-1:0] key_q_r;
  logic [CODE_W-1:0] cand_code_s;
  logic              cand_any_s;

  key_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  note_code_t        pend_r, pend_nxt_s;
  note_code_t        code_r, code_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              note_on_r, note_on_nxt_s;
  logic              note_off_r, note_off_nxt_s;
  logic              multi_r;

  prio_encoder u_prio (
    .key_q     (key_q_r),
    .cand_code (cand_code_s),
    .cand_any  (cand_any_s)
  );

  // Next-state, counter and output decisions of the debounce FSM.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    pend_nxt_s     = pend_r;
    code_nxt_s     = code_r;
    valid_nxt_s    = valid_r;
    note_on_nxt_s  = 1'b0;
    note_off_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cand_any_s) begin
          state_nxt_s = DEBOUNCE;
          pend_nxt_s  = cand_code_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DEBOUNCE: begin
        if (!cand_any_s) begin
          state_nxt_s = IDLE;
        end else if (cand_code_s != pend_r) begin
          pend_nxt_s = cand_code_s;
          cnt_nxt_s  = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = HELD;
          code_nxt_s    = pend_r;
          valid_nxt_s   = 1'b1;
          note_on_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (!cand_any_s || (cand_code_s != code_r)) begin
          state_nxt_s = RELEASE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = HELD;
        end
      end
      RELEASE: begin
        // A brief return of the held key is a glitch, not a new press.
        if (cand_any_s && (cand_code_s == code_r)) begin
          state_nxt_s = HELD;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s    = IDLE;
          valid_nxt_s    = 1'b0;
          note_off_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, input stage and registered outputs; reset never emits note_off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      key_q_r    <= {N_KEYS{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      pend_r     <= {CODE_W{1'b0}};
      code_r     <= {CODE_W{1'b0}};
      valid_r    <= 1'b0;
      note_on_r  <= 1'b0;
      note_off_r <= 1'b0;
      multi_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      key_q_r    <= keys & {N_KEYS{enable}};
      cnt_r      <= cnt_nxt_s;
      pend_r     <= pend_nxt_s;
      code_r     <= code_nxt_s;
      valid_r    <= valid_nxt_s;
      note_on_r  <= note_on_nxt_s;
      note_off_r <= note_off_nxt_s;
      multi_r    <= more_than_one(key_q_r);
    end
  end

  assign code     = code_r;
  assign valid    = valid_r;
  assign note_on  = note_on_r;
  assign note_off = note_off_r;
  assign multi    = multi_r;

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder: directed segment table plus random
// stimulus compared every cycle against a run-length reference model.
module tb_key_encoder;
  import piano_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] keys;
  logic [2:0] code;
  logic       valid, note_on, note_off, multi;

  always #5 clk = ~clk;

  key_encoder #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .reset    (reset),
    .keys     (keys),
    .enable   (enable),
    .code     (code),
    .valid    (valid),
    .note_on  (note_on),
    .note_off (note_off),
    .multi    (multi)
  );

  typedef struct {
    int         cyc;
    logic       rst;
    logic       en;
    logic [7:0] k;
    logic       e_valid;
    logic [2:0] e_code;
    logic       e_on;
    logic       e_off;
    logic       e_multi;
  } seg_t;

  seg_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: a note is accepted after DEB+1 consecutive identical
  // non-empty candidate samples, released after DEB+1 consecutive samples
  // that do not show the held note.
  logic [7:0] m_kq;
  int         m_run;
  int         m_runcode;
  logic       m_valid, m_on, m_off, m_multi;
  logic [2:0] m_code;

  task automatic model_edge(input logic r, input logic e, input logic [7:0] k);
    logic [7:0] s;
    int c;
    if (r) begin
      m_kq = 8'h00; m_run = 0; m_runcode = 0;
      m_valid = 1'b0; m_on = 1'b0; m_off = 1'b0; m_multi = 1'b0; m_code = 3'd0;
    end else begin
      s = m_kq;
      c = -1;
      for (int i = 0; i < 8; i++) if (s[i] && c < 0) c = i;
      m_on = 1'b0;
      m_off = 1'b0;
      if (!m_valid) begin
        if (c >= 0 && m_run > 0 && c == m_runcode) m_run++;
        else if (c >= 0) begin m_run = 1; m_runcode = c; end
        else m_run = 0;
        if (m_run == DEB + 1) begin
          m_valid = 1'b1; m_code = 3'(c); m_on = 1'b1; m_run = 0;
        end
      end else begin
        if (c >= 0 && 3'(c) == m_code) m_run = 0;
        else m_run++;
        if (m_run == DEB + 1) begin
          m_valid = 1'b0; m_off = 1'b1; m_run = 0;
        end
      end
      m_multi = ($countones(s) > 1);
      m_kq = k & {8{e}};
    end
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: valid,code,on,off,multi got %b required %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] k);
    reset = r; enable = e; keys = k;
    @(posedge clk);
    model_edge(r, e, k);
    if (r) chk_on = 1'b1;
    @(negedge clk);
    if (chk_on)
      check("model", {valid, code, note_on, note_off, multi},
            {m_valid, m_code, m_on, m_off, m_multi});
  endtask

  task automatic add(input int cyc, input logic r, input logic e, input logic [7:0] k,
                     input logic v, input logic [2:0] cd, input logic on,
                     input logic off, input logic mu);
    seg_t s;
    s.cyc = cyc; s.rst = r; s.en = e; s.k = k;
    s.e_valid = v; s.e_code = cd; s.e_on = on; s.e_off = off; s.e_multi = mu;
    tbl.push_back(s);
  endtask

  initial begin
    logic [7:0] rk;
    logic       ren;
    logic       rrst;
    reset = 1'b1; enable = 1'b0; keys = 8'h00;

    // press / release of key 2
    add(2, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(5, 1'b0, 1'b1, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    add(12, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    add(5, 1'b0, 1'b1, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    // bounce before a clean press
    add(2, 1'b0, 1'b1, 8'h04, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(5, 1'b0, 1'b1, 8'h04, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    add(7, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    // two keys, then the priority key drops
    add(1, 1'b0, 1'b1, 8'h24, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h24, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    add(3, 1'b0, 1'b1, 8'h24, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    add(1, 1'b0, 1'b1, 8'h24, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    add(5, 1'b0, 1'b1, 8'h20, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h20, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    add(4, 1'b0, 1'b1, 8'h20, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'h20, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    // glitch on a held note is rejected
    add(7, 1'b0, 1'b1, 8'h00, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
    add(6, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    add(2, 1'b0, 1'b1, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    add(10, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    // enable drop acts as release
    add(7, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    add(6, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    add(5, 1'b0, 1'b0, 8'h02, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 8'h02, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    // reset while held: everything clears, no note_off
    add(6, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    add(2, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1, 8'h02, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    // all keys pressed but disabled
    add(20, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].cyc; j++) step(tbl[i].rst, tbl[i].en, tbl[i].k);
      check($sformatf("table[%0d]", i), {valid, code, note_on, note_off, multi},
            {tbl[i].e_valid, tbl[i].e_code, tbl[i].e_on, tbl[i].e_off, tbl[i].e_multi});
    end

    rk = 8'h00;
    ren = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rk = 8'h00;
          1: rk = 8'h01 << $urandom_range(0, 7);
          2: rk = 8'($urandom);
          default: rk = rk | (8'h01 << $urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 63) == 0) ren = ~ren;
      rrst = ($urandom_range(0, 299) == 0);
      step(rrst, ren, rk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
